// File: rtl/fifo_srl.sv
// Shift-register FIFO with a first-word-fall-through read side: if_dout shows
// the oldest word whenever if_empty_n is high, and if_read pops it.
module fifo_srl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
);

    localparam int AW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] CNT_ZERO = AW'(0);
    localparam logic [AW-1:0] CNT_MAX  = AW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         count_q;
    logic [AW-1:0]         count_d;
    logic [PW-1:0]         rd_addr_s;
    logic                  wr_s;
    logic                  rd_s;

    assign wr_s       = if_write & if_write_ce & (count_q != CNT_MAX);
    assign rd_s       = if_read & if_read_ce & (count_q != CNT_ZERO);
    assign if_full_n  = (count_q != CNT_MAX);
    assign if_empty_n = (count_q != CNT_ZERO);
    assign if_dout    = mem_q[rd_addr_s];

    // Oldest word sits at the deepest occupied stage of the shift chain.
    always_comb begin
        if (count_q == CNT_ZERO) begin
            rd_addr_s = PW'(0);
        end else begin
            rd_addr_s = PW'(count_q - AW'(1));
        end
    end

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + AW'(1);
            2'b01:   count_d = count_q - AW'(1);
            default: count_d = count_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    // Data shift chain; contents are qualified by count_q so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[0] <= if_din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

endmodule

// File: rtl/fifo_read_relay.sv
// Two-entry registered relay behind a FWFT FIFO read port. Breaks the path from
// consumer if_read back into the FIFO while keeping a FWFT interface at 1 word/cycle.
module fifo_read_relay #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  up_empty_n,
    input  logic [DATA_WIDTH-1:0] up_dout,
    output logic                  up_read,
    output logic                  up_read_ce,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic [DATA_WIDTH-1:0] slot0_q;
    logic [DATA_WIDTH-1:0] slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q;
    logic [DATA_WIDTH-1:0] slot1_d;
    logic                  empty_n_q;
    logic                  push_s;
    logic                  pop_s;

    // Push looks only at registered occupancy so if_read never reaches upstream.
    assign push_s     = reset_n & up_empty_n & (count_q != CNT_FULL);
    assign pop_s      = if_read & if_read_ce & (count_q != CNT_EMPTY);
    assign up_read    = push_s;
    assign up_read_ce = 1'b1;
    assign if_empty_n = empty_n_q;
    assign if_dout    = slot0_q;

    // Slot and occupancy next-state.
    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == CNT_EMPTY) begin
                    slot0_d = up_dout;
                end else begin
                    slot1_d = up_dout;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at CNT_ONE: the head leaves and the new word replaces it.
                slot0_d = up_dout;
                count_d = CNT_ONE;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State registers; empty flag is registered from count_d so it is a flop output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= CNT_EMPTY;
            slot0_q   <= {DATA_WIDTH{1'b0}};
            slot1_q   <= {DATA_WIDTH{1'b0}};
            empty_n_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            empty_n_q <= (count_d != CNT_EMPTY);
        end
    end

endmodule

// File: tb/tb_fifo_read_relay.sv
// Bench: fifo_srl (DEPTH=4) feeds fifo_read_relay; a queue scoreboard checks order.
module tb_fifo_read_relay;

    logic        clk;
    logic        reset_n;
    logic        fifo_rst_n;
    logic        fifo_wr;
    logic [31:0] fifo_din;
    logic        fifo_full_n;
    logic        up_empty_n;
    logic [31:0] up_dout;
    logic        up_read;
    logic        up_read_ce;
    logic        if_empty_n;
    logic        if_read_ce;
    logic        if_read;
    logic [31:0] if_dout;

    int          n_checks;
    int          n_fail;
    logic [31:0] src_q [$];
    logic [31:0] exp_q [$];

    fifo_srl #(.DATA_WIDTH(32), .DEPTH(4)) u_fifo (
        .clk        (clk),
        .reset_n    (fifo_rst_n),
        .if_full_n  (fifo_full_n),
        .if_write_ce(1'b1),
        .if_write   (fifo_wr),
        .if_din     (fifo_din),
        .if_empty_n (up_empty_n),
        .if_read_ce (up_read_ce),
        .if_read    (up_read),
        .if_dout    (up_dout)
    );

    fifo_read_relay #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .up_empty_n(up_empty_n),
        .up_dout   (up_dout),
        .up_read   (up_read),
        .up_read_ce(up_read_ce),
        .if_empty_n(if_empty_n),
        .if_read_ce(if_read_ce),
        .if_read   (if_read),
        .if_dout   (if_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Invariants, sampled mid low phase once bench inputs have settled.
    always @(negedge clk) begin
        #3;
        n_checks++;
        if (up_read && !up_empty_n) begin
            n_fail++;
            $display("FAIL inv_up_read_empty: up_read=%b up_empty_n=%b", up_read, up_empty_n);
        end
        n_checks++;
        if (up_read_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_up_read_ce: got %b expected 1", up_read_ce);
        end
        n_checks++;
        if (!reset_n && up_read) begin
            n_fail++;
            $display("FAIL inv_read_in_reset: up_read=%b while reset_n=0", up_read);
        end
        n_checks++;
        if (dut.count_q > 2'd2) begin
            n_fail++;
            $display("FAIL inv_count: got %0d expected <=2", dut.count_q);
        end
    end

    // One clock of stimulus, entered and left at a negedge. Reports whether the
    // consumer pop is accepted on the coming edge, the head word and up_read.
    task automatic cycle(input bit wr, input bit rd, input bit ce,
                         output bit popped, output logic [31:0] got, output bit ur);
        fifo_wr    = wr && (src_q.size() != 0);
        fifo_din   = fifo_wr ? src_q[0] : 32'h0;
        if_read    = rd;
        if_read_ce = ce;
        #1;
        if (fifo_wr && fifo_full_n) begin
            exp_q.push_back(src_q.pop_front());
        end
        popped = if_empty_n && rd && ce;
        got    = if_dout;
        ur     = up_read;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit p, ur;
        logic [31:0] g, e;
        reset_n    = 1'b0;
        fifo_rst_n = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, 1'b0, p, g, ur);
        fifo_rst_n = 1'b1;
        src_q.push_back(32'h1111_0000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, p, g, ur);
            n_checks++;
            if (ur !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_up_read: got %b expected 0 (cycle %0d)", ur, i);
            end
        end
        n_checks++;
        if (if_empty_n !== 1'b0 || if_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got empty_n=%b dout=%h expected 0/00000000", if_empty_n, if_dout);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || src_q.size() != 0); c++) begin
            cycle(1'b1, 1'b1, 1'b1, p, g, ur);
            if (p) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL reset_drain: got %h expected %h", g, e);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain_timeout: got %0d left expected 0", exp_q.size());
        end
    endtask

    task automatic test_single();
        bit p, ur;
        logic [31:0] g, e;
        src_q.push_back(32'hA5A5_0001);
        cycle(1'b1, 1'b0, 1'b0, p, g, ur);
        n_checks++;
        if (up_read !== 1'b1) begin
            n_fail++;
            $display("FAIL single_up_read: got %b expected 1", up_read);
        end
        cycle(1'b0, 1'b0, 1'b0, p, g, ur);
        n_checks++;
        if (if_empty_n !== 1'b1 || if_dout !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL single_visible: got empty_n=%b dout=%h expected 1/a5a50001", if_empty_n, if_dout);
        end
        cycle(1'b0, 1'b1, 1'b1, p, g, ur);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n_checks++;
        if (!p || g !== e) begin
            n_fail++;
            $display("FAIL single_pop: got popped=%b data=%h expected 1/%h", p, g, e);
        end
        n_checks++;
        if (if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty_after: got %b expected 0", if_empty_n);
        end
    endtask

    task automatic test_stream();
        bit p, ur, started;
        logic [31:0] g, e;
        int npop;
        npop    = 0;
        started = 1'b0;
        for (int i = 0; i < 64; i++) src_q.push_back(32'(i));
        for (int c = 0; c < 300 && npop < 64; c++) begin
            cycle(1'b1, 1'b1, 1'b1, p, g, ur);
            if (p) begin
                started = 1'b1;
                npop++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL stream_data: got %h expected %h", g, e);
                end
            end else if (started) begin
                n_checks++;
                n_fail++;
                $display("FAIL stream_bubble: got no word expected word %0d", npop);
            end
        end
        n_checks++;
        if (npop != 64) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 64", npop);
        end
    endtask

    task automatic test_backpressure();
        bit p, ur;
        logic [31:0] g, e;
        int nur, npop;
        nur  = 0;
        npop = 0;
        for (int i = 0; i < 5; i++) src_q.push_back(32'hB000_0000 + 32'(i));
        for (int c = 0; c < 12; c++) begin
            cycle(1'b1, 1'b0, 1'b0, p, g, ur);
            nur += int'(ur);
        end
        n_checks++;
        if (nur != 2) begin
            n_fail++;
            $display("FAIL bp_entered: got %0d expected 2", nur);
        end
        n_checks++;
        if (up_read !== 1'b0 || if_empty_n !== 1'b1 || if_dout !== 32'hB000_0000) begin
            n_fail++;
            $display("FAIL bp_hold: got up_read=%b empty_n=%b dout=%h expected 0/1/b0000000", up_read, if_empty_n, if_dout);
        end
        for (int c = 0; c < 40 && (exp_q.size() != 0 || src_q.size() != 0); c++) begin
            cycle(1'b1, 1'b1, 1'b1, p, g, ur);
            if (p) begin
                npop++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL bp_data: got %h expected %h", g, e);
                end
            end
        end
        n_checks++;
        if (npop != 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected 5", npop);
        end
    endtask

    task automatic test_random();
        bit p, ur, wr, rd, ce;
        logic [31:0] g, e;
        for (int i = 0; i < 1000; i++) src_q.push_back($urandom);
        for (int c = 0; c < 20000 && (exp_q.size() != 0 || src_q.size() != 0); c++) begin
            wr = ($urandom_range(0, 99) >= 30);
            rd = ($urandom_range(0, 1) == 1);
            ce = ($urandom_range(0, 1) == 1);
            cycle(wr, rd, ce, p, g, ur);
            if (p) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL random_data: got %h expected %h", g, e);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0 || src_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_timeout: got %0d left expected 0", exp_q.size() + src_q.size());
        end
        n_checks++;
        if (if_empty_n !== 1'b0) begin
            n_fail++;
            $display("FAIL random_empty_end: got %b expected 0", if_empty_n);
        end
    endtask

    task automatic test_mid_reset();
        bit p, ur;
        logic [31:0] g, e;
        int npop;
        npop = 0;
        for (int i = 0; i < 6; i++) src_q.push_back(32'hC000_0000 + 32'(i));
        repeat (10) cycle(1'b1, 1'b0, 1'b0, p, g, ur);
        n_checks++;
        if (up_read !== 1'b0 || if_empty_n !== 1'b1 || up_empty_n !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full: got up_read=%b empty_n=%b up_empty_n=%b expected 0/1/1", up_read, if_empty_n, up_empty_n);
        end
        reset_n = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, p, g, ur);
        n_checks++;
        if (ur !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_up_read: got %b expected 0", ur);
        end
        reset_n = 1'b1;
        n_checks++;
        if (if_empty_n !== 1'b0 || if_dout !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_cleared: got empty_n=%b dout=%h expected 0/00000000", if_empty_n, if_dout);
        end
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        for (int c = 0; c < 40 && (exp_q.size() != 0 || src_q.size() != 0); c++) begin
            cycle(1'b1, 1'b1, 1'b1, p, g, ur);
            if (p) begin
                npop++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL mid_data: got %h expected %h", g, e);
                end
            end
        end
        n_checks++;
        if (npop != 4) begin
            n_fail++;
            $display("FAIL mid_count: got %0d expected 4", npop);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        fifo_rst_n = 1'b0;
        fifo_wr    = 1'b0;
        fifo_din   = 32'h0;
        if_read    = 1'b0;
        if_read_ce = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
